// File: rtl/jesd_rx_link_ctrl.sv
// jesd_rx_link_ctrl: single-lane JESD204B RX link bring-up (SYNC~/CGS/ILAS/DATA) for the ECP5 DCU.
// Define JESD_RX_ERR_CNT_EN to add the saturating error-octet statistics counter (err_count / err_count_clr).

module jesd_rx_oct_match #(
   parameter logic [7:0] CHAR = 8'hBC
) (
   input  logic [7:0] oct,
   input  logic       k,
   output logic       hit
);
   assign hit = k && (oct == CHAR);
endmodule

module jesd_rx_link_ctrl #(
   parameter int CGS_K_COUNT      = 4,
   parameter int ILAS_MULTIFRAMES = 4,
   parameter int ILAS_TIMEOUT     = 4096,
   parameter int ERR_THRESH       = 4
) (
   input  logic        link_clk,
   input  logic        link_resetn,
   input  logic        serdes_ready,
   input  logic        resync_req,
   input  logic [15:0] rxd,
   input  logic [1:0]  rx_k,
   input  logic [1:0]  rx_disp_err,
   input  logic [1:0]  rx_cv_err,
`ifdef JESD_RX_ERR_CNT_EN
   input  logic        err_count_clr,
   output logic [15:0] err_count,
`endif
   output logic        dsync_n,
   output logic        phy_en_char_align,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic [1:0]  link_state,
   output logic        byte_offset
);
   localparam int NUM_OCT = 2;
   localparam int CGS_W   = $clog2(CGS_K_COUNT + 1);
   localparam int A_W     = $clog2(ILAS_MULTIFRAMES + 1);
   localparam int TMR_W   = $clog2(ILAS_TIMEOUT + 1);
   localparam int ERR_W   = $clog2(ERR_THRESH + 1);

   typedef enum logic [1:0] {
      ST_WAIT_PHY = 2'd0,
      ST_CGS      = 2'd1,
      ST_ILAS     = 2'd2,
      ST_DATA     = 2'd3
   } state_t;

   typedef struct packed {
      logic [NUM_OCT-1:0][7:0] d;
      logic [NUM_OCT-1:0]      k;
      logic [NUM_OCT-1:0]      err;
   } word_t;

   state_t             state, nxt;
   word_t              raw, prev, aln;
   logic [NUM_OCT-1:0] raw_is_k, raw_is_r, aln_is_a;
   logic [CGS_W-1:0]   cgs_cnt;
   logic [A_W-1:0]     a_cnt;
   logic [TMR_W-1:0]   ilas_tmr;
   logic [ERR_W-1:0]   err_cnt;
   logic               r_seen;
   logic               cgs_ok, cgs_done, a_hit, ilas_done, ilas_tmo;
   logic               data_err, err_hit, enter_cgs;

   assign raw = {rxd, rx_k, rx_disp_err | rx_cv_err};

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn) prev <= '0;
      else              prev <= raw;
   end

   // Offset 1 splices the current low octet above the previous high octet.
   always_comb begin
      aln = prev;
      if (byte_offset)
         aln = {raw.d[0], prev.d[1], raw.k[0], prev.k[1], raw.err[0], prev.err[1]};
   end

   for (genvar g = 0; g < NUM_OCT; g++) begin : g_oct
      jesd_rx_oct_match #(.CHAR(8'hBC)) u_raw_k (.oct(raw.d[g]), .k(raw.k[g]), .hit(raw_is_k[g]));
      jesd_rx_oct_match #(.CHAR(8'h1C)) u_raw_r (.oct(raw.d[g]), .k(raw.k[g]), .hit(raw_is_r[g]));
      jesd_rx_oct_match #(.CHAR(8'h7C)) u_aln_a (.oct(aln.d[g]), .k(aln.k[g]), .hit(aln_is_a[g]));
   end

   assign cgs_ok    = &(raw_is_k & ~raw.err);
   assign cgs_done  = cgs_ok && (cgs_cnt == CGS_W'(CGS_K_COUNT - 1));
   assign a_hit     = r_seen && (|aln_is_a);
   assign ilas_done = a_hit && (a_cnt == A_W'(ILAS_MULTIFRAMES - 1));
   assign ilas_tmo  = (ilas_tmr == TMR_W'(ILAS_TIMEOUT - 1));
   assign data_err  = |aln.err;
   assign err_hit   = data_err && (err_cnt == ERR_W'(ERR_THRESH - 1));

   always_comb begin
      nxt = state;
      case (state)
         ST_WAIT_PHY: if (serdes_ready) nxt = ST_CGS;
         ST_CGS:      if (cgs_done) nxt = ST_ILAS;
         ST_ILAS:     if (ilas_done) nxt = ST_DATA;
                      else if (ilas_tmo) nxt = ST_CGS;
         ST_DATA:     if (err_hit) nxt = ST_CGS;
         default:     nxt = ST_WAIT_PHY;
      endcase
      if (resync_req && (state != ST_WAIT_PHY)) nxt = ST_CGS;
      if (!serdes_ready) nxt = ST_WAIT_PHY;
   end

   // A resync while already in CGS counts as a fresh entry.
   assign enter_cgs = (nxt == ST_CGS) && ((state != ST_CGS) || resync_req);

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn) begin
         state             <= ST_WAIT_PHY;
         dsync_n           <= 1'b0;
         phy_en_char_align <= 1'b0;
         data_out          <= '0;
         data_valid        <= 1'b0;
         byte_offset       <= 1'b0;
         r_seen            <= 1'b0;
         cgs_cnt           <= '0;
         a_cnt             <= '0;
         ilas_tmr          <= '0;
         err_cnt           <= '0;
      end else begin
         state             <= nxt;
         dsync_n           <= (nxt == ST_ILAS) || (nxt == ST_DATA);
         phy_en_char_align <= (nxt == ST_CGS);
         data_valid        <= (state == ST_DATA) && (nxt == ST_DATA);
         if (state == ST_DATA) data_out <= aln.d;
         if (enter_cgs) begin
            byte_offset <= 1'b0;
            r_seen      <= 1'b0;
            cgs_cnt     <= '0;
            a_cnt       <= '0;
            ilas_tmr    <= '0;
            err_cnt     <= '0;
         end else begin
            case (state)
               ST_CGS: cgs_cnt <= cgs_ok ? cgs_cnt + 1'b1 : '0;
               ST_ILAS: begin
                  ilas_tmr <= ilas_tmr + 1'b1;
                  // Low octet wins when /R/ shows up in both.
                  if (!r_seen && (|raw_is_r)) begin
                     r_seen      <= 1'b1;
                     byte_offset <= ~raw_is_r[0];
                  end
                  if (a_hit) a_cnt <= a_cnt + 1'b1;
               end
               ST_DATA: if (data_err) err_cnt <= err_cnt + 1'b1;
               default: ;
            endcase
            if ((nxt == ST_DATA) && (state != ST_DATA)) err_cnt <= '0;
         end
      end
   end

   assign link_state = state;

`ifdef JESD_RX_ERR_CNT_EN
   logic [16:0] err_sum;

   assign err_sum = {1'b0, err_count} + 17'(aln.err[0]) + 17'(aln.err[1]);

   always_ff @(posedge link_clk or negedge link_resetn) begin
      if (!link_resetn)
         err_count <= '0;
      else if (err_count_clr)
         err_count <= '0;
      else if (state != ST_WAIT_PHY)
         err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end
`endif

endmodule
